fifo_read_stage: RTL and testbench

FIFO_READ_STAGE -- requirements
Module: fifo_read_stage

---
 rtl/fifo_read_stage_if.sv | 33 +++
 rtl/fifo_read_stage.sv | 61 ++++++
 tb/tb_fifo_read_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_read_stage_if.sv
// rtl/fifo_read_stage_if.sv - FIFO-controller / downstream handshake bundle for fifo_read_stage.
interface fifo_read_stage_if #(
  parameter int stack_width = 8,
  parameter int cnt_width   = 16
);
  logic                   stack_empty;
  logic [stack_width-1:0] stack_data_in;
  logic                   read_from_stack;
  logic [stack_width-1:0] data_out;
  logic                   data_valid;
  logic                   data_ready;
  logic [cnt_width-1:0]   word_count;

  modport master (
    input  stack_empty,
    input  stack_data_in,
    input  data_ready,
    output read_from_stack,
    output data_out,
    output data_valid,
    output word_count
  );

  modport slave (
    output stack_empty,
    output stack_data_in,
    output data_ready,
    input  read_from_stack,
    input  data_out,
    input  data_valid,
    input  word_count
  );
endinterface

// File: rtl/fifo_read_stage.sv
// rtl/fifo_read_stage.sv - pops a one-cycle-latency FIFO memory into a 2-entry buffer feeding a ready/valid stream.
module fifo_read_stage #(
  parameter int stack_width = 8,
  parameter int cnt_width   = 16
) (
  input  logic               clk,
  input  logic               rst,
  fifo_read_stage_if.master  bus
);
  logic [stack_width-1:0] head_q, head_d;
  logic [stack_width-1:0] tail_q, tail_d;
  logic [1:0]             occ_q, occ_d;
  logic                   infl_q;
  logic [cnt_width-1:0]   cnt_q, cnt_d;
  logic                   pop_out;
  logic                   rd;
  logic [1:0]             base;

  always_comb begin
    pop_out = (occ_q != 2'd0) && bus.data_ready;
    base    = occ_q - {1'b0, pop_out};
    // Count the word already in flight so a pop never overruns the two slots.
    rd      = rst && !bus.stack_empty && ((base + {1'b0, infl_q}) < 2'd2);

    head_d = head_q;
    tail_d = tail_q;
    if (pop_out) begin
      head_d = tail_q;
    end
    if (infl_q) begin
      if (base == 2'd0) begin
        head_d = bus.stack_data_in;
      end else begin
        tail_d = bus.stack_data_in;
      end
    end
    occ_d = base + {1'b0, infl_q};
    cnt_d = cnt_q + cnt_width'(pop_out);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
      infl_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      infl_q <= rd;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.read_from_stack = rd;
  assign bus.data_valid      = (occ_q != 2'd0);
  assign bus.data_out        = (occ_q != 2'd0) ? head_q : '0;
  assign bus.word_count      = cnt_q;
endmodule

// File: tb/tb_fifo_read_stage.sv
// tb/tb_fifo_read_stage.sv - vector table plus scoreboard-driven sequences for fifo_read_stage.
module tb_fifo_read_stage;
  localparam int DW = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_read_stage_if #(.stack_width(DW), .cnt_width(CW)) bus ();
  fifo_read_stage #(.stack_width(DW), .cnt_width(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          fe;
    logic          rdy;
    logic          e_rd;
    logic          e_v;
    logic [DW-1:0] e_d;
  } vec_t;

  vec_t          vecs [16];
  logic [DW-1:0] mem [$];
  logic [DW-1:0] expq [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_deliv;
  int            vfirst, vlast, vcount;
  logic          infl_m, hold_v;
  logic [DW-1:0] hold_d;
  logic [CW-1:0] exp_cnt;
  logic          s_rd, s_v;
  logic [DW-1:0] s_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    expq.delete();
    mem.delete();
    infl_m  = 1'b0;
    hold_v  = 1'b0;
    exp_cnt = '0;
    n_deliv = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.data_ready  = 1'b0;
    bus.stack_empty = 1'b1;
    #1;
    chk("rst_rd", bus.read_from_stack, 0);
    chk("rst_valid", bus.data_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_count", bus.word_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_model();
  endtask

  // One clock cycle: drive at posedge+1, sample and score at the falling edge.
  task automatic step(input logic fe, input logic rdy);
    logic [DW-1:0] w;
    int            occ_m;
    w = '0;
    bus.data_ready  = rdy;
    bus.stack_empty = fe || (mem.size() == 0);
    #4;
    s_rd  = bus.read_from_stack;
    s_v   = bus.data_valid;
    s_d   = bus.data_out;
    occ_m = expq.size() - int'(infl_m);
    chk("valid_vs_model", s_v, occ_m > 0);
    chk("count", bus.word_count, exp_cnt);
    if (!s_v) chk("idle_data_zero", s_d, 0);
    if (hold_v) begin
      chk("hold_valid", s_v, 1);
      chk("hold_data", s_d, hold_d);
    end
    hold_v = s_v && !rdy;
    hold_d = s_d;
    if (s_v && rdy) begin
      if (expq.size() != 0) chk("order", s_d, expq.pop_front());
      exp_cnt++;
      n_deliv++;
    end
    chk("pop_suppressed", s_rd & bus.stack_empty, 0);
    if (s_rd && mem.size() != 0) begin
      w = mem.pop_front();
      expq.push_back(w);
    end
    chk("outstanding_le2", expq.size() <= 2, 1);
    infl_m = s_rd;
    @(posedge clk);
    #1;
    bus.stack_data_in = s_rd ? w : DW'($urandom);
  endtask

  task automatic drain(input int mode, input int limit);
    int k;
    k = 0;
    vfirst = -1; vlast = -1; vcount = 0;
    while (k < limit && (mem.size() != 0 || expq.size() != 0 || k < 2)) begin
      step(1'b0, (mode == 0) ? 1'b1 : (k % 2 == 0));
      if (s_v) begin
        if (vfirst < 0) vfirst = k;
        vlast = k;
        vcount++;
      end
      k++;
    end
    chk("drained", expq.size() + mem.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.stack_empty   = 1'b1;
    bus.stack_data_in = '0;
    bus.data_ready    = 1'b0;
    clear_model();

    // Single word, then a backpressured stream of 0x10..0x15.
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h10};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h10};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h12};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h13};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h14};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h15};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    #1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        do_reset();
        mem.push_back(8'hA5);
      end
      if (i == 4) begin
        chk("single_count", bus.word_count, 1);
        do_reset();
        for (int k = 0; k < 6; k++) mem.push_back(DW'(8'h10 + k));
      end
      step(vecs[i].fe, vecs[i].rdy);
      chk($sformatf("vec%0d_rd", i), s_rd, vecs[i].e_rd);
      chk($sformatf("vec%0d_valid", i), s_v, vecs[i].e_v);
      chk($sformatf("vec%0d_data", i), s_d, vecs[i].e_d);
    end
    chk("bp_count", bus.word_count, 6);

    // Continuous stream of eight words.
    do_reset();
    for (int k = 1; k <= 8; k++) mem.push_back(DW'(k));
    drain(0, 40);
    chk("stream_valid_cycles", vcount, 8);
    chk("stream_contiguous", vlast - vfirst + 1, 8);
    chk("stream_latency", vfirst, 2);
    chk("stream_count", bus.word_count, 8);

    // Alternating ready over six words.
    do_reset();
    for (int k = 0; k < 6; k++) mem.push_back(DW'(8'h40 + k * 3));
    drain(1, 60);
    chk("alt_delivered", n_deliv, 6);

    // Asynchronous reset with a full buffer and a pop being requested.
    do_reset();
    for (int k = 0; k < 5; k++) mem.push_back(DW'(8'h31 + k));
    step(1'b0, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    bus.data_ready  = 1'b1;
    bus.stack_empty = 1'b0;
    #2;
    chk("pre_rst_rd", bus.read_from_stack, 1);
    chk("pre_rst_valid", bus.data_valid, 1);
    chk("pre_rst_count", bus.word_count, 1);
    rst = 1'b0;
    #1;
    chk("async_rd", bus.read_from_stack, 0);
    chk("async_valid", bus.data_valid, 0);
    chk("async_data", bus.data_out, 0);
    chk("async_count", bus.word_count, 0);
    @(posedge clk);
    #1;
    chk("rst_hold_valid", bus.data_valid, 0);
    rst = 1'b1;
    clear_model();
    bus.stack_data_in = 8'hEE;
    repeat (6) step(1'b0, 1'b1);
    chk("no_stale_words", n_deliv, 0);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int k = 0; k < 17; k++) mem.push_back(DW'(8'h80 + k));
    drain(0, 60);
    chk("wrap_delivered", n_deliv, 17);
    chk("wrap_count", bus.word_count, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
